fetch_unit: RTL

Parametrised instruction-fetch stage. It succeeds the free-running PC, +4 adder and instruction-memory chain in the CPU top level. It owns the PC and drives a synchronous-read instruction memory port. Returned {pc, inst} pairs are buffered in a small FIFO and presented to decode over a valid/ready handshake. Branch/jump redirects flush the buffer and discard any in-flight read.

---
 rtl/fetch_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC and issues synchronous-read requests.
// Returned {pc, inst} pairs are buffered and handed to decode over valid/ready.
module fetch_unit #(
  parameter int               ADDR_W     = 32,
  parameter int               DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int               FIFO_DEPTH = 4,
  parameter int               INST_BYTES = DATA_W / 8
) (
  input  logic                        clock,
  input  logic                        reset,
  output logic                        imem_en,
  output logic [ADDR_W-1:0]           imem_addr,
  input  logic [DATA_W-1:0]           imem_rdata,
  input  logic                        redirect_valid,
  input  logic [ADDR_W-1:0]           redirect_pc,
  output logic                        inst_valid,
  input  logic                        inst_ready,
  output logic [DATA_W-1:0]           inst_data,
  output logic [ADDR_W-1:0]           inst_pc,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issue_pc;
  logic              inflight;
  logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] pc_mem   [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occupancy;
  logic              push;
  logic              pop;

  // The in-flight read reserves a slot so a response can never meet a full buffer.
  assign occupancy  = {1'b0, count} + (CNT_W + 1)'(inflight);
  assign imem_en    = !reset && !redirect_valid && (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_addr  = pc;
  assign push       = inflight && !redirect_valid && !reset;
  assign inst_valid = (count != '0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = data_mem[rd_ptr];
  assign inst_pc    = pc_mem[rd_ptr];
  assign fifo_count = count;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= RESET_PC;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ALIGN_MASK;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_en;
      if (imem_en) pc <= pc + STEP;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Remembers which address the outstanding read belongs to.
  always_ff @(posedge clock) begin
    if (imem_en) issue_pc <= pc;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= issue_pc;
    end
  end

endmodule
